// File: rtl/alarm_ring_controller.sv
// rtl/alarm_ring_controller.sv - alarm ring/snooze/lockout sequencer with blinking LED
module alarm_ring_controller #(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int MAX_SNOOZE     = 3,
   parameter int SCW            = $clog2(MAX_SNOOZE + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tick_1hz,
   input  logic           alarm_enable,
   input  logic           time_match,
   input  logic           stop_btn,
   input  logic           snooze_btn,
   output logic           ringing,
   output logic           alarm_led,
   output logic           snooze_led,
   output logic [SCW-1:0] snooze_count,
   output logic [2:0]     state_out
);

   localparam int RCW = $clog2(RING_TIMEOUT_S + 1);
   localparam int SZW = $clog2(SNOOZE_S + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_RINGING = 3'd2,
      S_SNOOZE  = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   state_t         state;
   logic [RCW-1:0] ring_cnt;
   logic [SZW-1:0] snz_cnt;
   logic           blink;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         ring_cnt     <= '0;
         snz_cnt      <= '0;
         snooze_count <= '0;
         blink        <= 1'b0;
      end else if (!alarm_enable) begin
         state        <= S_IDLE;
         ring_cnt     <= '0;
         snz_cnt      <= '0;
         snooze_count <= '0;
         blink        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: state <= S_ARMED;
            S_ARMED: begin
               if (time_match) begin
                  state        <= S_RINGING;
                  ring_cnt     <= '0;
                  blink        <= 1'b1;
                  snooze_count <= '0;
               end
            end
            S_RINGING: begin
               // buttons take precedence; a tick in the same clk is dropped
               if (stop_btn) begin
                  state <= S_LOCKOUT;
               end else if (snooze_btn && (snooze_count < SCW'(MAX_SNOOZE))) begin
                  state        <= S_SNOOZE;
                  snooze_count <= snooze_count + 1'b1;
                  snz_cnt      <= '0;
               end else if (tick_1hz) begin
                  blink <= ~blink;
                  if (ring_cnt == RCW'(RING_TIMEOUT_S - 1))
                     state <= S_LOCKOUT;
                  else
                     ring_cnt <= ring_cnt + 1'b1;
               end
            end
            S_SNOOZE: begin
               if (stop_btn) begin
                  state <= S_LOCKOUT;
               end else if (tick_1hz) begin
                  if (snz_cnt == SZW'(SNOOZE_S - 1)) begin
                     state    <= S_RINGING;
                     ring_cnt <= '0;
                     blink    <= 1'b1;
                  end else begin
                     snz_cnt <= snz_cnt + 1'b1;
                  end
               end
            end
            // wait for the matching minute to pass so the alarm cannot retrigger
            S_LOCKOUT: begin
               if (!time_match)
                  state <= S_ARMED;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ringing    = (state == S_RINGING);
   assign alarm_led  = ringing & blink;
   assign snooze_led = (state == S_SNOOZE);
   assign state_out  = state;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// tb/tb_alarm_ring_controller.sv - directed bench for alarm_ring_controller
module tb_alarm_ring_controller;

   localparam int SCW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           tick_1hz;
   logic           alarm_enable;
   logic           time_match;
   logic           stop_btn;
   logic           snooze_btn;
   logic           ringing;
   logic           alarm_led;
   logic           snooze_led;
   logic [SCW-1:0] snooze_count;
   logic [2:0]     state_out;

   int checks = 0;
   int errors = 0;

   alarm_ring_controller #(
      .RING_TIMEOUT_S(5),
      .SNOOZE_S      (3),
      .MAX_SNOOZE    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_1hz    (tick_1hz),
      .alarm_enable(alarm_enable),
      .time_match  (time_match),
      .stop_btn    (stop_btn),
      .snooze_btn  (snooze_btn),
      .ringing     (ringing),
      .alarm_led   (alarm_led),
      .snooze_led  (snooze_led),
      .snooze_count(snooze_count),
      .state_out   (state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one clk worth of pulses, sampled at the next posedge
   task automatic cyc(input logic t, input logic s, input logic z);
      tick_1hz   = t;
      stop_btn   = s;
      snooze_btn = z;
      @(negedge clk);
      tick_1hz   = 1'b0;
      stop_btn   = 1'b0;
      snooze_btn = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tick_1hz = 0; alarm_enable = 0; time_match = 0; stop_btn = 0; snooze_btn = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_state", 32'(state_out), 0);
      chk("rst_ringing", 32'(ringing), 0);
      chk("rst_snz_cnt", 32'(snooze_count), 0);

      // basic ring and timeout
      alarm_enable = 1; time_match = 1;
      cyc(0, 0, 0);
      chk("armed", 32'(state_out), 1);
      cyc(0, 0, 0);
      chk("ring_entry", 32'(state_out), 2);
      for (int i = 0; i < 5; i++) begin
         chk("ring_on", 32'(ringing), 1);
         chk("led_pat", 32'(alarm_led), (i % 2 == 0) ? 1 : 0);
         cyc(1, 0, 0);
      end
      chk("timeout_lockout", 32'(state_out), 4);
      chk("timeout_ring_off", 32'(ringing), 0);
      time_match = 0;
      cyc(0, 0, 0);
      chk("lockout_release", 32'(state_out), 1);

      // snooze cycles up to the limit
      time_match = 1;
      cyc(0, 0, 0);
      chk("ring2", 32'(state_out), 2);
      cyc(0, 0, 1);
      chk("snz1_led", 32'(snooze_led), 1);
      chk("snz1_cnt", 32'(snooze_count), 1);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("snz1_hold", 32'(state_out), 3);
      cyc(1, 0, 0);
      chk("snz1_resume", 32'(state_out), 2);
      chk("snz1_resume_led", 32'(alarm_led), 1);
      cyc(0, 0, 1);
      chk("snz2_cnt", 32'(snooze_count), 2);
      chk("snz2_state", 32'(state_out), 3);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("snz2_resume", 32'(state_out), 2);
      cyc(0, 0, 1);
      chk("snz3_ignored", 32'(ringing), 1);
      chk("snz3_cnt", 32'(snooze_count), 2);

      // stop beats snooze in the same clk
      cyc(0, 1, 1);
      chk("stop_wins", 32'(state_out), 4);
      chk("stop_cnt_held", 32'(snooze_count), 2);
      cyc(0, 0, 0);
      chk("lockout_hold", 32'(state_out), 4);
      time_match = 0;
      cyc(0, 0, 0);
      chk("lockout_exit", 32'(state_out), 1);

      // disable while snoozing
      time_match = 1;
      cyc(0, 0, 0);
      chk("ring3_cnt_clr", 32'(snooze_count), 0);
      cyc(0, 0, 1);
      chk("snz_again", 32'(state_out), 3);
      alarm_enable = 0;
      cyc(0, 0, 0);
      chk("disable_idle", 32'(state_out), 0);
      chk("disable_cnt", 32'(snooze_count), 0);
      alarm_enable = 1;
      cyc(0, 0, 0);
      chk("reen_armed", 32'(state_out), 1);
      cyc(0, 0, 0);
      chk("reen_ring", 32'(state_out), 2);

      // stop coincident with the terminal tick
      for (int i = 0; i < 4; i++) cyc(1, 0, 0);
      chk("pre_term_state", 32'(state_out), 2);
      chk("pre_term_led", 32'(alarm_led), 1);
      cyc(1, 1, 0);
      chk("stop_tick_state", 32'(state_out), 4);
      chk("stop_tick_led", 32'(alarm_led), 0);

      // async reset mid-ring
      time_match = 0;
      cyc(0, 0, 0);
      time_match = 1;
      cyc(0, 0, 0);
      chk("pre_rst_ring", 32'(ringing), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_state", 32'(state_out), 0);
      chk("async_ringing", 32'(ringing), 0);
      chk("async_led", 32'(alarm_led), 0);
      chk("async_snz_led", 32'(snooze_led), 0);
      chk("async_cnt", 32'(snooze_count), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
